// File: rtl/ikbd_acia_if.sv
// Register-bus interface between the 68000-side host and the IKBD ACIA.
// The host drives the access strobe, direction, select and write data.
// The ACIA returns registered read data and an active-low interrupt.
interface ikbd_acia_if;
    logic       cs;
    logic       we;
    logic       rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq_n;

    modport master (
        output cs,
        output we,
        output rs,
        output din,
        input  dout,
        input  irq_n
    );

    modport slave (
        input  cs,
        input  we,
        input  rs,
        input  din,
        output dout,
        output irq_n
    );
endinterface

// File: rtl/ikbd_acia.sv
// IKBD-link ACIA: 6850-style serial endpoint with fixed 8N1 framing.
// It receives the keyboard controller byte stream on rxd and sends host
// commands on txd. The RX and TX machines are independent; they share
// only the status/control register block.
module ikbd_acia #(
    parameter int CLKS_PER_BIT = 256
) (
    input  logic        clk,
    input  logic        res,
    ikbd_acia_if.slave  bus,
    input  logic        rxd,
    output logic        txd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Bus decode
    logic ctrl_wr, data_wr, stat_rd, data_rd, mres;

    assign ctrl_wr = bus.cs &  bus.we & ~bus.rs;
    assign data_wr = bus.cs &  bus.we &  bus.rs;
    assign stat_rd = bus.cs & ~bus.we & ~bus.rs;
    assign data_rd = bus.cs & ~bus.we &  bus.rs;
    assign mres    = ctrl_wr & (bus.din[1:0] == 2'b11);

    // Register block state
    logic [7:0] rdr, tdr;
    logic       rdrf, tdre, fe, ovrn, rie, tie;
    logic       irq;
    logic [7:0] status;

    // RX machine state
    rx_state_t  rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic       rx_done, rx_stop;
    logic       rx_meta, rx_sync;

    // TX machine state
    tx_state_t  tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0] tx_bit, tx_bit_n;
    logic [7:0] tx_shift, tx_shift_n;
    logic       tx_load;

    assign irq       = (rie & (rdrf | ovrn)) | (tie & tdre);
    assign bus.irq_n = ~irq;
    assign status    = {irq, 1'b0, ovrn, fe, 2'b00, tdre, rdrf};

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
        end
    end

    // RX state register; a master reset aborts any frame in progress
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (mres) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // RX next state: half-bit start qualification, then mid-bit sampling
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        rx_stop    = 1'b1;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = HALF;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (!rx_sync) begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = FULL;
                        rx_bit_n   = '0;
                    end else begin
                        rx_state_n = RX_IDLE;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    rx_cnt_n   = FULL;
                    if (rx_bit == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_done    = 1'b1;
                    rx_stop    = rx_sync;
                    rx_state_n = rx_sync ? RX_IDLE : RX_BREAK;
                end else begin
                    rx_cnt_n = rx_cnt - 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_sync) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    // TX state register; a master reset drops the line back to idle
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (mres) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
        end
    end

    // TX next state: a pending byte is picked up in IDLE or straight out of
    // the final stop-bit cycle, so back-to-back frames abut with no gap
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_load    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tdre) begin
                    tx_load    = 1'b1;
                    tx_shift_n = tdr;
                    tx_cnt_n   = FULL;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = FULL;
                    tx_bit_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_cnt_n   = FULL;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == '0) begin
                    if (!tdre) begin
                        tx_load    = 1'b1;
                        tx_shift_n = tdr;
                        tx_cnt_n   = FULL;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
            end
        endcase
    end

    // Line level follows the TX state; idle and stop are both mark
    always_comb begin
        txd = 1'b1;
        case (tx_state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift[0];
            default:  txd = 1'b1;
        endcase
    end

    // Register block: later assignments take priority, so a completing
    // frame beats a same-cycle data read and a host write beats a TX load
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rdr      <= '0;
            tdr      <= '0;
            rdrf     <= 1'b0;
            tdre     <= 1'b1;
            fe       <= 1'b0;
            ovrn     <= 1'b0;
            rie      <= 1'b0;
            tie      <= 1'b0;
            bus.dout <= '0;
        end else if (mres) begin
            rdr      <= '0;
            tdr      <= '0;
            rdrf     <= 1'b0;
            tdre     <= 1'b1;
            fe       <= 1'b0;
            ovrn     <= 1'b0;
            rie      <= bus.din[7];
            tie      <= (bus.din[6:5] == 2'b01);
            bus.dout <= '0;
        end else begin
            if (ctrl_wr) begin
                rie <= bus.din[7];
                tie <= (bus.din[6:5] == 2'b01);
            end
            if (tx_load) begin
                tdre <= 1'b1;
            end
            if (data_wr) begin
                tdr  <= bus.din;
                tdre <= 1'b0;
            end
            if (stat_rd) begin
                bus.dout <= status;
            end
            if (data_rd) begin
                bus.dout <= rdr;
                rdrf     <= 1'b0;
                fe       <= 1'b0;
                ovrn     <= 1'b0;
            end
            if (rx_done) begin
                fe <= ~rx_stop;
                if (!rdrf || data_rd) begin
                    rdr  <= rx_shift;
                    rdrf <= 1'b1;
                end else begin
                    ovrn <= 1'b1;
                end
            end
        end
    end

endmodule
